// File: rtl/ws281x_bit_engine.sv
// ws281x_bit_engine: one-wire LED serializer for a single ws281x port.
// Pops 24-bit GRB words from the port FIFO and shifts them out MSB first.
// Each bit is high for th0/th1 cycles and then low for the rest of its period.
// When the FIFO runs dry, a reset (latch) gap is inserted before going idle.
module ws281x_bit_engine #(
  parameter int NB = 24,
  parameter int CW = 10,
  parameter int RW = 16
) (
  input  logic          mclk,
  input  logic          h_reset_n,
  input  logic [RW-1:0] cfg_reset_period,
  input  logic [CW-1:0] cfg_clk_period,
  input  logic [CW-1:0] cfg_th0_period,
  input  logic [CW-1:0] cfg_th1_period,
  input  logic          port_enb,
  input  logic          port_dval,
  input  logic [NB-1:0] port_data,
  output logic          port_rd,
  output logic          txd,
  output logic          busy
);

  localparam int BW = $clog2(NB);

  typedef enum logic [1:0] {IDLE, BIT, RST} state_t;

  state_t        state, state_nx;
  logic [NB-1:0] sr, sr_nx;
  logic [BW-1:0] bit_cnt, bit_cnt_nx;
  logic [CW-1:0] cyc, cyc_nx;
  logic [RW-1:0] rcnt, rcnt_nx;
  logic [CW-1:0] per_q, per_nx;
  logic [CW-1:0] th0_q, th0_nx;
  logic [CW-1:0] th1_q, th1_nx;
  logic [RW-1:0] rst_q, rst_nx;
  logic [CW-1:0] th_sel;
  logic          txd_nx;
  logic          avail;
  logic          pop;

  assign avail = port_enb & port_dval;

  // Next-state logic: word load, bit stepping, reset gap, and the output bit that follows.
  always_comb begin
    state_nx   = state;
    sr_nx      = sr;
    bit_cnt_nx = bit_cnt;
    cyc_nx     = cyc;
    rcnt_nx    = rcnt;
    per_nx     = per_q;
    th0_nx     = th0_q;
    th1_nx     = th1_q;
    rst_nx     = rst_q;
    pop        = 1'b0;
    case (state)
      IDLE: begin
        if (avail) begin
          pop        = 1'b1;
          state_nx   = BIT;
          sr_nx      = port_data;
          bit_cnt_nx = BW'(NB - 1);
          cyc_nx     = '0;
          per_nx     = cfg_clk_period;
          th0_nx     = cfg_th0_period;
          th1_nx     = cfg_th1_period;
          rst_nx     = cfg_reset_period;
        end
      end
      BIT: begin
        if (cyc == per_q) begin
          cyc_nx = '0;
          if (bit_cnt != '0) begin
            sr_nx      = {sr[NB-2:0], 1'b0};
            bit_cnt_nx = bit_cnt - BW'(1);
          end else if (avail) begin
            // Back-to-back word: reload on the last cycle so no gap cycle appears.
            pop        = 1'b1;
            sr_nx      = port_data;
            bit_cnt_nx = BW'(NB - 1);
            per_nx     = cfg_clk_period;
            th0_nx     = cfg_th0_period;
            th1_nx     = cfg_th1_period;
            rst_nx     = cfg_reset_period;
          end else begin
            state_nx = RST;
            rcnt_nx  = '0;
          end
        end else begin
          cyc_nx = cyc + CW'(1);
        end
      end
      RST: begin
        if (rcnt == rst_q) begin
          state_nx = IDLE;
          rcnt_nx  = '0;
        end else begin
          rcnt_nx = rcnt + RW'(1);
        end
      end
      default: state_nx = IDLE;
    endcase
    // txd is registered, so it is computed from the values the state takes next cycle.
    th_sel = sr_nx[NB-1] ? th1_nx : th0_nx;
    txd_nx = (state_nx == BIT) && (cyc_nx < th_sel);
  end

  // State, counters, latched timing and the registered line output.
  always_ff @(posedge mclk or negedge h_reset_n) begin
    if (!h_reset_n) begin
      state   <= IDLE;
      sr      <= '0;
      bit_cnt <= '0;
      cyc     <= '0;
      rcnt    <= '0;
      per_q   <= '0;
      th0_q   <= '0;
      th1_q   <= '0;
      rst_q   <= '0;
      txd     <= 1'b0;
    end else begin
      state   <= state_nx;
      sr      <= sr_nx;
      bit_cnt <= bit_cnt_nx;
      cyc     <= cyc_nx;
      rcnt    <= rcnt_nx;
      per_q   <= per_nx;
      th0_q   <= th0_nx;
      th1_q   <= th1_nx;
      rst_q   <= rst_nx;
      txd     <= txd_nx;
    end
  end

  // The pop is masked during reset so a FIFO word is never consumed while held in reset.
  assign port_rd = pop & h_reset_n;
  assign busy    = (state != IDLE);

endmodule
